// File: rtl/rename_commit_unit.sv
// In-order graduation unit for the rename pipeline: holds rename records in program
// order, retires completed records from the head and returns old phys regs to the free list.
module rename_commit_unit #(
    parameter int DEPTH  = 32,
    parameter int TAG_W  = 5,
    parameter int PHYS_W = 6,
    parameter int ARCH_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [ARCH_W-1:0] alloc_arch,
    input  logic [PHYS_W-1:0] alloc_new_phys,
    input  logic [PHYS_W-1:0] alloc_old_phys,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic              rb_valid,
    input  logic [TAG_W-1:0]  rb_tag,
    output logic              free_valid,
    input  logic              free_ready,
    output logic [PHYS_W-1:0] free_phys,
    output logic              commit_valid,
    output logic [ARCH_W-1:0] commit_arch,
    output logic [PHYS_W-1:0] commit_phys,
    output logic [TAG_W:0]    count,
    output logic              empty
);

    localparam logic [TAG_W:0] DEPTH_L = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0] ONE_L   = (TAG_W+1)'(1);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [ARCH_W-1:0] r_arch     [DEPTH];
    logic [PHYS_W-1:0] r_new_phys [DEPTH];
    logic [PHYS_W-1:0] r_old_phys [DEPTH];
    logic [TAG_W:0]    r_head;
    logic [TAG_W:0]    r_tail;
    logic              r_free_valid;
    logic [PHYS_W-1:0] r_free_phys;
    logic              r_commit_valid;
    logic [ARCH_W-1:0] r_commit_arch;
    logic [PHYS_W-1:0] r_commit_phys;

    logic [TAG_W:0]    w_count;
    logic [TAG_W-1:0]  w_head_idx;
    logic [TAG_W-1:0]  w_tail_idx;
    logic [TAG_W-1:0]  w_rb_rel;
    logic [TAG_W-1:0]  w_off [DEPTH];
    logic [DEPTH-1:0]  w_squash;
    logic              w_alloc_fire;
    logic              w_commit;
    logic              w_wb_hit;

    // Occupancy, handshakes and rollback squash mask (offset from head beyond the branch).
    always_comb begin
        w_count      = r_tail - r_head;
        w_head_idx   = r_head[TAG_W-1:0];
        w_tail_idx   = r_tail[TAG_W-1:0];
        w_rb_rel     = rb_tag - w_head_idx;
        alloc_ready  = (w_count < DEPTH_L) && !rb_valid;
        w_alloc_fire = alloc_valid && alloc_ready;
        w_squash     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i]    = TAG_W'(i) - w_head_idx;
            w_squash[i] = rb_valid && (w_off[i] > w_rb_rel);
        end
        w_commit = r_valid[w_head_idx] && r_done[w_head_idx] && (!r_free_valid || free_ready);
        // A writeback may target the record being allocated in the same cycle.
        w_wb_hit = wb_valid && !w_squash[wb_tag]
                   && (r_valid[wb_tag] || (w_alloc_fire && (wb_tag == w_tail_idx)));
    end

    // Per-entry valid/done bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_fire && (w_tail_idx == TAG_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_done[i]  <= w_wb_hit && (wb_tag == TAG_W'(i));
                end else if ((w_commit && (w_head_idx == TAG_W'(i))) || w_squash[i]) begin
                    r_valid[i] <= 1'b0;
                    r_done[i]  <= 1'b0;
                end else if (w_wb_hit && (wb_tag == TAG_W'(i))) begin
                    r_done[i]  <= 1'b1;
                end else begin
                    r_valid[i] <= r_valid[i];
                    r_done[i]  <= r_done[i];
                end
            end
        end
    end

    // Record payload written at the tail.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_arch[w_tail_idx]     <= alloc_arch;
            r_new_phys[w_tail_idx] <= alloc_new_phys;
            r_old_phys[w_tail_idx] <= alloc_old_phys;
        end
    end

    // Head/tail pointers; rollback rebuilds the tail from the pre-commit head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_commit) begin
                r_head <= r_head + ONE_L;
            end
            if (rb_valid) begin
                r_tail <= r_head + {1'b0, w_rb_rel} + ONE_L;
            end else if (w_alloc_fire) begin
                r_tail <= r_tail + ONE_L;
            end
        end
    end

    // Registered commit pulse and free-list offer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_commit_valid <= 1'b0;
            r_commit_arch  <= '0;
            r_commit_phys  <= '0;
            r_free_valid   <= 1'b0;
            r_free_phys    <= '0;
        end else begin
            r_commit_valid <= w_commit;
            if (w_commit) begin
                r_commit_arch <= r_arch[w_head_idx];
                r_commit_phys <= r_new_phys[w_head_idx];
                r_free_valid  <= 1'b1;
                r_free_phys   <= r_old_phys[w_head_idx];
            end else if (r_free_valid && free_ready) begin
                r_free_valid  <= 1'b0;
            end
        end
    end

    assign alloc_tag    = w_tail_idx;
    assign count        = w_count;
    assign empty        = (w_count == '0);
    assign free_valid   = r_free_valid;
    assign free_phys    = r_free_phys;
    assign commit_valid = r_commit_valid;
    assign commit_arch  = r_commit_arch;
    assign commit_phys  = r_commit_phys;

endmodule

// File: tb/tb_rename_commit_unit.sv
// Directed bench for rename_commit_unit: stimulus pushes expected retirements into
// queues, a negedge monitor pops and compares commit and free-list traffic.
module tb_rename_commit_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_valid, alloc_ready;
    logic [4:0] alloc_arch;
    logic [5:0] alloc_new_phys, alloc_old_phys;
    logic [4:0] alloc_tag;
    logic       wb_valid;
    logic [4:0] wb_tag;
    logic       rb_valid;
    logic [4:0] rb_tag;
    logic       free_valid, free_ready;
    logic [5:0] free_phys;
    logic       commit_valid;
    logic [4:0] commit_arch;
    logic [5:0] commit_phys;
    logic [5:0] count;
    logic       empty;

    int checks = 0;
    int errors = 0;
    int n_commits = 0;
    int nc0;
    int cq_arch[$];
    int cq_phys[$];
    int fq[$];
    int mon_a, mon_p;

    rename_commit_unit dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_arch(alloc_arch),
        .alloc_new_phys(alloc_new_phys), .alloc_old_phys(alloc_old_phys), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .rb_valid(rb_valid), .rb_tag(rb_tag),
        .free_valid(free_valid), .free_ready(free_ready), .free_phys(free_phys),
        .commit_valid(commit_valid), .commit_arch(commit_arch), .commit_phys(commit_phys),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        cq_arch.delete();
        cq_phys.delete();
        fq.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0; rb_valid = 1'b0;
        step();
        rst_n = 1'b1;
        free_ready = 1'b1;
        clear_sb();
    endtask

    task automatic alloc(input int arch, input int np, input int op, input int wbt);
        alloc_valid = 1'b1;
        alloc_arch = 5'(arch); alloc_new_phys = 6'(np); alloc_old_phys = 6'(op);
        if (wbt >= 0) begin
            wb_valid = 1'b1;
            wb_tag = 5'(wbt);
        end
        cq_arch.push_back(arch); cq_phys.push_back(np); fq.push_back(op);
        step();
        alloc_valid = 1'b0;
        wb_valid = 1'b0;
    endtask

    task automatic wb(input int t);
        wb_valid = 1'b1;
        wb_tag = 5'(t);
        step();
        wb_valid = 1'b0;
    endtask

    // Scoreboard monitor: every retirement and free transfer must match program order.
    always @(negedge clk) begin
        if (commit_valid === 1'b1) begin
            n_commits++;
            if (cq_arch.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_commit actual=%0d expected=none", commit_arch);
            end else begin
                mon_a = cq_arch.pop_front();
                mon_p = cq_phys.pop_front();
                chk("commit_arch", 32'(commit_arch), 32'(mon_a));
                chk("commit_phys", 32'(commit_phys), 32'(mon_p));
            end
        end
        if (free_valid === 1'b1 && free_ready === 1'b1) begin
            if (fq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_free actual=%0d expected=none", free_phys);
            end else begin
                mon_p = fq.pop_front();
                chk("free_phys", 32'(free_phys), 32'(mon_p));
            end
        end
    end

    initial begin
        rst_n = 1'b0; alloc_valid = 1'b0; alloc_arch = '0; alloc_new_phys = '0;
        alloc_old_phys = '0; wb_valid = 1'b0; wb_tag = '0; rb_valid = 1'b0;
        rb_tag = '0; free_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        chk("rst_free_valid", 32'(free_valid), 32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);

        // Fill to DEPTH, then a refused 33rd alloc
        for (int i = 0; i < 32; i++) begin
            chk("fill_tag", 32'(alloc_tag), 32'(i));
            alloc(i, i, i, -1);
        end
        chk("full_count", 32'(count), 32'd32);
        chk("full_ready", 32'(alloc_ready), 32'd0);
        chk("full_empty", 32'(empty), 32'd0);
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        chk("full_count_hold", 32'(count), 32'd32);
        chk("full_tag_hold", 32'(alloc_tag), 32'd0);

        // Out-of-order writeback, in-order retirement
        do_reset();
        alloc(1, 10, 40, -1); alloc(2, 11, 41, -1); alloc(3, 12, 42, -1);
        nc0 = n_commits;
        wb(2); chk("ooo_no_commit_a", 32'(commit_valid), 32'd0);
        wb(1); chk("ooo_no_commit_b", 32'(commit_valid), 32'd0);
        wb(0); chk("ooo_no_commit_c", 32'(commit_valid), 32'd0);
        step(); chk("ooo_c0", 32'(commit_valid), 32'd1); chk("ooo_f0", 32'(free_phys), 32'd40);
        step(); chk("ooo_c1", 32'(commit_valid), 32'd1); chk("ooo_f1", 32'(free_phys), 32'd41);
        step(); chk("ooo_c2", 32'(commit_valid), 32'd1); chk("ooo_f2", 32'(free_phys), 32'd42);
        chk("ooo_count", 32'(count), 32'd0);
        step(); chk("ooo_pulse_end", 32'(commit_valid), 32'd0);
        chk("ooo_free_clear", 32'(free_valid), 32'd0);
        chk("ooo_ncommits", 32'(n_commits - nc0), 32'd3);

        // Free-list backpressure
        do_reset();
        free_ready = 1'b0;
        alloc(5, 20, 50, -1); alloc(6, 21, 51, -1);
        wb(0); wb(1);
        chk("bp_first_commit", 32'(commit_valid), 32'd1);
        chk("bp_free_valid", 32'(free_valid), 32'd1);
        chk("bp_count", 32'(count), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_valid", 32'(free_valid), 32'd1);
            chk("bp_hold_phys", 32'(free_phys), 32'd50);
            chk("bp_hold_count", 32'(count), 32'd1);
            chk("bp_no_commit", 32'(commit_valid), 32'd0);
        end
        free_ready = 1'b1;
        step();
        chk("bp_b2b_phys", 32'(free_phys), 32'd51);
        chk("bp_b2b_valid", 32'(free_valid), 32'd1);
        chk("bp_b2b_count", 32'(count), 32'd0);
        chk("bp_b2b_commit", 32'(commit_valid), 32'd1);
        step();
        chk("bp_drain", 32'(free_valid), 32'd0);

        // Rollback truncation with a blocked alloc the same cycle
        do_reset();
        for (int i = 0; i < 6; i++) alloc(i, 30 + i, 50 + i, -1);
        rb_valid = 1'b1; rb_tag = 5'd2;
        alloc_valid = 1'b1; alloc_arch = 5'd31; alloc_new_phys = 6'd63; alloc_old_phys = 6'd63;
        #1;
        chk("rb_ready", 32'(alloc_ready), 32'd0);
        step();
        rb_valid = 1'b0; alloc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            void'(cq_arch.pop_back()); void'(cq_phys.pop_back()); void'(fq.pop_back());
        end
        chk("rb_count", 32'(count), 32'd3);
        chk("rb_tag_next", 32'(alloc_tag), 32'd3);
        wb(4);
        chk("rb_wb_ignored_count", 32'(count), 32'd3);
        chk("rb_wb_no_commit", 32'(commit_valid), 32'd0);
        nc0 = n_commits;
        wb(0); wb(1); wb(2); step(); step();
        chk("rb_drain_count", 32'(count), 32'd0);
        chk("rb_drain_commits", 32'(n_commits - nc0), 32'd3);
        // Same-cycle alloc + writeback at the head
        alloc(7, 45, 55, 3);
        chk("lat_count", 32'(count), 32'd1);
        chk("lat_no_commit", 32'(commit_valid), 32'd0);
        step();
        chk("lat_commit", 32'(commit_valid), 32'd1);
        chk("lat_phys", 32'(commit_phys), 32'd45);
        chk("lat_count0", 32'(count), 32'd0);
        step();

        // Streaming through pointer wrap
        do_reset();
        for (int i = 0; i < 40; i++) begin
            chk("wrap_ready", 32'(alloc_ready), 32'd1);
            chk("wrap_tag", 32'(alloc_tag), 32'(i % 32));
            alloc(i % 32, i % 64, (i + 7) % 64, i % 32);
            chk("wrap_count", 32'(count), 32'd1);
            chk("wrap_empty", 32'(empty), 32'd0);
        end
        step(); step();
        chk("wrap_end_count", 32'(count), 32'd0);
        chk("wrap_end_empty", 32'(empty), 32'd1);
        chk("wrap_sb_commit", 32'(cq_arch.size()), 32'd0);
        chk("wrap_sb_free", 32'(fq.size()), 32'd0);

        // Reset mid-operation with a pending free offer
        do_reset();
        for (int i = 0; i < 10; i++) alloc(i, i, i + 20, -1);
        free_ready = 1'b0;
        wb(0); step();
        chk("mid_count", 32'(count), 32'd9);
        chk("mid_free_valid", 32'(free_valid), 32'd1);
        do_reset();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_free", 32'(free_valid), 32'd0);
        chk("mid_rst_tag", 32'(alloc_tag), 32'd0);
        chk("mid_rst_commit", 32'(commit_valid), 32'd0);
        chk("mid_rst_ready", 32'(alloc_ready), 32'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_commit_unit.md
Name: rename_commit_unit

Overview:
- In-order graduation unit at the far end of the register-renaming pipeline.
- Receives one rename record per accepted instruction: arch dest, new phys, old phys. Holds these in program order.
- Marks records complete on writeback and retires them in order from the head. On retire, returns the old physical register to the free list through a valid/ready channel.
- Truncates younger records on branch-mispredict rollback.

Parameters:
- DEPTH, 32, number of in-flight records (power of two).
- TAG_W, 5, log2(DEPTH); width of record tags.
- PHYS_W, 6, physical register index width (64 phys regs).
- ARCH_W, 5, architectural register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- alloc_valid  in  1  rename presents a record.
- alloc_ready  out  1  record can be accepted.
- alloc_arch  in  ARCH_W  architectural destination.
- alloc_new_phys  in  PHYS_W  newly mapped phys reg.
- alloc_old_phys  in  PHYS_W  previous mapping, freed at commit.
- alloc_tag  out  TAG_W  tag assigned to the presented record (tail index).
- wb_valid  in  1  writeback completion.
- wb_tag  in  TAG_W  tag of completed record.
- rb_valid  in  1  rollback request.
- rb_tag  in  TAG_W  tag of mispredicted branch; it and all older records are kept.
- free_valid  out  1  old phys reg offered to free list.
- free_ready  in  1  free list accepts.
- free_phys  out  PHYS_W  phys reg being returned.
- commit_valid  out  1  one-cycle pulse per retired record.
- commit_arch  out  ARCH_W  arch reg of retired record.
- commit_phys  out  PHYS_W  new phys of retired record (architectural map update).
- count  out  TAG_W+1  occupied records.
- empty  out  1  count==0.

Behaviour:
- Storage: DEPTH entries, each {valid, done, arch, new_phys, old_phys}.
- Pointers: head_ptr and tail_ptr are TAG_W+1 bits; MSB is the wrap bit. count = tail_ptr-head_ptr.
- Reset (rst_n=0 at an edge):
  - All entries invalid; head_ptr=tail_ptr=0.
  - free_valid=0, free_phys=0, commit_valid=0, commit_arch=0, commit_phys=0.
  - Hence count=0, empty=1, alloc_ready=1, alloc_tag=0.
  - Reset mid-operation discards all records and any pending free_valid offer.
- Combinational outputs:
  - alloc_ready = (count<DEPTH) && !rb_valid.
  - alloc_tag = tail_ptr[TAG_W-1:0].
- Allocation: on alloc_valid&&alloc_ready, write the entry at the tail with valid=1, done=0; tail_ptr+=1. Pointers wrap modulo 2*DEPTH.
- Writeback: if wb_valid and entry[wb_tag].valid, set done=1 at the edge.
  - wb to an invalid tag is ignored.
  - wb to a tag squashed by rollback in the same cycle is ignored.
  - wb to an already-done entry has no effect.
- Commit condition, evaluated each cycle: head entry valid && done && (!free_valid || free_ready).
  - On commit at an edge: head entry invalidated, head_ptr+=1.
  - Registered outputs at that edge: commit_valid=1, commit_arch, commit_phys=new_phys, free_valid=1, free_phys=old_phys.
  - Maximum one commit per cycle.
- Commit latency: a record allocated and written back in the same cycle N, at the head, commits at edge N+1. commit_valid and free_valid are visible in cycle N+1.
- commit_valid is a single-cycle pulse and deasserts the next cycle unless another commit occurs.
- Free handshake:
  - free_valid and free_phys hold stable until free_valid&&free_ready.
  - On that transfer with no new commit, free_valid clears.
  - If a commit occurs on the same edge as the transfer, the new value is loaded back-to-back.
  - Commit stalls while free_valid&&!free_ready.
- Rollback (rb_valid): keep = ((rb_tag-head_idx) mod DEPTH)+1; tail_ptr := head_ptr+keep. Entries beyond are invalidated.
  - rb_tag must name a valid entry; otherwise behaviour is undefined.
  - Allocation is blocked that cycle because alloc_ready=0.
  - A head commit in the same cycle proceeds normally.
  - If rb_tag is the head and the head commits, the result is count=0.
- Full: count==DEPTH deasserts alloc_ready. Wrap bits distinguish full from empty.
- Simultaneous alloc+commit: count unchanged.

Test Plan:
- Reset, then 32 allocs with no wb -> alloc_tag 0..31; count=32, alloc_ready=0. 33rd alloc_valid is not accepted and tail is unchanged.
- Alloc tags 0,1,2 (old_phys 40,41,42); wb 2, then 1 -> no commit_valid. Then wb 0 -> commits on 3 consecutive cycles with free_phys 40,41,42.
- Head done with free_ready=0 for 4 cycles -> first commit occurs; free_valid=1 and free_phys held for 4 cycles; no second commit until the transfer; count decrements only on commits.
- Alloc tags 0..5, rb_tag=2 with alloc_valid=1 the same cycle -> count=3, alloc not accepted, next alloc_tag=3. A later wb to tag 4 is ignored.
- Wrap-around: 40 alloc/wb/commit pairs streamed -> tags wrap 31->0; no spurious full or empty; free_phys order matches alloc order.
- Reset asserted with 10 records and free_valid=1 pending -> next cycle count=0, empty=1, free_valid=0, alloc_tag=0.
